// File: rtl/flash_pkg.sv
// flash_pkg: shared state encoding and command constants for the flash command engine.
package flash_pkg;
  typedef enum logic [3:0] {
    READ, UNLK1, UNLK2, PROG, ASEL, E_80, E_UNLK1, E_UNLK2, BUSY_PROG, BUSY_ERASE
  } flash_state_t;
  localparam logic [7:0] CMD_UNLK1 = 8'hAA;
  localparam logic [7:0] CMD_UNLK2 = 8'h55;
  localparam logic [7:0] CMD_PROG  = 8'hA0;
  localparam logic [7:0] CMD_ASEL  = 8'h90;
  localparam logic [7:0] CMD_ERASE = 8'h80;
  localparam logic [7:0] CMD_SECT  = 8'h30;
  localparam logic [7:0] CMD_CHIP  = 8'h10;
  localparam logic [7:0] CMD_RESET = 8'hF0;
  localparam logic [11:0] ADDR_UNLK1 = 12'hAAA;
  localparam logic [11:0] ADDR_UNLK2 = 12'h555;
endpackage

// File: rtl/flash_erase_walker.sv
// flash_erase_walker: steps an erase window one byte per ram_ack and pulses done on the final ack.
module flash_erase_walker #(
  parameter int ADDR_W = 23,
  parameter int CW = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [CW-1:0]     len,
  input  logic              ack,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);
  logic [CW-1:0] cur, left;
  assign req = left != '0;
  assign done = req && ack && left == CW'(1);
  assign addr = cur[ADDR_W-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur <= '0;
      left <= '0;
    end else if (start) begin
      cur <= CW'(base);
      left <= len;
    end else if (req && ack) begin
      cur <= cur + CW'(1);
      left <= left - CW'(1);
    end
endmodule

// File: rtl/flash_cmd_engine.sv
// flash_cmd_engine: AMD/JEDEC NOR command interpreter writing an SDRAM backing store.
// Define FLASH_CHIP_ERASE_EN to accept the AAA<-10 chip-erase command.
module flash_cmd_engine
  import flash_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int SECTOR_W = 16,
  parameter logic [7:0] MANUF_ID = 8'h01,
  parameter logic [7:0] DEVICE_ID = 8'h7E
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  input  logic              wr,
  input  logic              rd,
  output logic [7:0]        dout,
  output logic              dout_ovr,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_req,
  input  logic              ram_ack
);
`ifdef FLASH_CHIP_ERASE_EN
  localparam int CW = ADDR_W + 1;
`else
  localparam int CW = ADDR_W;
`endif
  flash_state_t state, nxt;
  logic bw, br, tgl, prog_req, chip, start, walk_req, walk_done;
  logic [7:0] prog_din;
  logic [11:0] a;
  logic [ADDR_W-1:0] prog_addr, walk_addr, base;
  logic [CW-1:0] len;
  assign bw = ce & wr;
  assign br = ce & rd;
  assign a = addr[11:0];
`ifdef FLASH_CHIP_ERASE_EN
  assign chip = a == ADDR_UNLK1 && din == CMD_CHIP;
  assign len = chip ? CW'(1) << ADDR_W : CW'(1) << SECTOR_W;
`else
  assign chip = 1'b0;
  assign len = CW'(1) << SECTOR_W;
`endif
  assign base = chip ? '0 : addr & ~((ADDR_W'(1) << SECTOR_W) - ADDR_W'(1));
  assign busy = state == BUSY_PROG || state == BUSY_ERASE;
  assign dout_ovr = busy || state == ASEL;
  assign dout = state == BUSY_PROG  ? {~prog_din[7], tgl, 6'b000000} :
                state == BUSY_ERASE ? {1'b0, tgl, 6'b001000} :
                state != ASEL       ? 8'hFF :
                addr[7:0] == 8'h00  ? MANUF_ID :
                addr[7:0] == 8'h02  ? DEVICE_ID : 8'h00;
  assign ram_req = prog_req | walk_req;
  assign ram_addr = state == BUSY_ERASE ? walk_addr : prog_addr;
  assign ram_din = state == BUSY_ERASE ? 8'hFF : prog_din;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= READ;
    else state <= nxt;
  always_comb begin
    nxt = state;
    start = 1'b0;
    if (bw && !busy) begin
      if (din == CMD_RESET) nxt = READ;
      else
        case (state)
          READ:    nxt = a == ADDR_UNLK1 && din == CMD_UNLK1 ? UNLK1 : READ;
          UNLK1:   nxt = a == ADDR_UNLK2 && din == CMD_UNLK2 ? UNLK2 : READ;
          UNLK2:   nxt = a != ADDR_UNLK1  ? READ :
                         din == CMD_PROG  ? PROG :
                         din == CMD_ASEL  ? ASEL :
                         din == CMD_ERASE ? E_80 : READ;
          E_80:    nxt = a == ADDR_UNLK1 && din == CMD_UNLK1 ? E_UNLK1 : READ;
          E_UNLK1: nxt = a == ADDR_UNLK2 && din == CMD_UNLK2 ? E_UNLK2 : READ;
          E_UNLK2: begin
            start = din == CMD_SECT || chip;
            nxt = start ? BUSY_ERASE : READ;
          end
          PROG:    nxt = BUSY_PROG;
          default: nxt = state;
        endcase
    end
    if (state == BUSY_PROG && prog_req && ram_ack) nxt = READ;
    if (state == BUSY_ERASE && walk_done) nxt = READ;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prog_addr <= '0;
      prog_din <= 8'hFF;
      prog_req <= 1'b0;
      tgl <= 1'b0;
    end else begin
      if (state == PROG && nxt == BUSY_PROG) begin
        prog_addr <= addr;
        prog_din <= din;
        prog_req <= 1'b1;
      end else if (prog_req && ram_ack) prog_req <= 1'b0;
      // a write in the same cycle as a read freezes the toggle bit
      tgl <= nxt == READ ? 1'b0 : busy && br && !bw ? ~tgl : tgl;
    end
  flash_erase_walker #(.ADDR_W(ADDR_W), .CW(CW)) u_walker (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base(base),
    .len(len),
    .ack(ram_ack),
    .req(walk_req),
    .addr(walk_addr),
    .done(walk_done)
  );
endmodule

// File: tb/tb_flash_cmd_engine.sv
// tb_flash_cmd_engine: directed bench with a RAM-write scoreboard for flash_cmd_engine.
module tb_flash_cmd_engine;
  logic clk = 0, reset = 1, ce = 0, wr = 0, rd = 0, ram_ack = 0;
  logic [22:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout, ram_din, rdat;
  logic dout_ovr, busy, ram_req;
  logic [22:0] ram_addr;
  int compared = 0, mism = 0, acks = 0, ack_wait = 0, wcnt = 0;
  logic [30:0] sb[$];

  flash_cmd_engine dut (
    .clk(clk), .reset(reset), .ce(ce), .addr(addr), .din(din), .wr(wr), .rd(rd),
    .dout(dout), .dout_ovr(dout_ovr), .busy(busy), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_req(ram_req), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mism++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [22:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = 1; wr = 1; addr = a; din = d;
    @(negedge clk);
    ce = 0; wr = 0;
  endtask

  task automatic bus_rd(input logic [22:0] a, output logic [7:0] d);
    @(negedge clk);
    ce = 1; rd = 1; addr = a;
    #1 d = dout;
    @(negedge clk);
    ce = 0; rd = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  // SDRAM arbiter model: acks after ack_wait cycles and checks each write against the scoreboard
  initial forever begin
    @(negedge clk);
    ram_ack = 0;
    if (ram_req && !reset) begin
      if (wcnt < ack_wait) wcnt++;
      else begin
        wcnt = 0;
        acks++;
        ram_ack = 1;
        compared++;
        assert (sb.size() > 0 && {ram_addr, ram_din} === sb[0]) else begin
          mism++;
          $error("FAIL ram_write: got %h/%h, expected %h", ram_addr, ram_din,
                 sb.size() > 0 ? sb[0] : 31'h0);
        end
        if (sb.size() > 0) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_dout", 32'(dout), 32'hFF);
    chk("rst_ovr", 32'(dout_ovr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req", 32'(ram_req), 32'h0);
    chk("rst_raddr", 32'(ram_addr), 32'h0);
    chk("rst_rdin", 32'(ram_din), 32'hFF);

    ack_wait = 3;
    sb.push_back({23'h012345, 8'h3C});
    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h55);
    bus_wr(23'hAAA, 8'hA0);
    bus_wr(23'h012345, 8'h3C);
    chk("prog_req", 32'(ram_req), 32'h1);
    chk("prog_raddr", 32'(ram_addr), 32'h012345);
    chk("prog_rdin", 32'(ram_din), 32'h3C);
    chk("prog_busy", 32'(busy), 32'h1);
    bus_rd(23'h0, rdat);
    chk("prog_stat0", 32'(rdat), 32'h80);
    chk("prog_ovr", 32'(dout_ovr), 32'h1);
    bus_rd(23'h0, rdat);
    chk("prog_stat1", 32'(rdat), 32'hC0);
    wait_idle(20);
    chk("prog_ovr_end", 32'(dout_ovr), 32'h0);
    chk("prog_acks", 32'(acks), 32'h1);
    chk("prog_sb_empty", 32'(sb.size()), 32'h0);

    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h55);
    bus_wr(23'hAAA, 8'h90);
    bus_rd(23'h0, rdat);
    chk("asel_manuf", 32'(rdat), 32'h01);
    chk("asel_ovr", 32'(dout_ovr), 32'h1);
    bus_rd(23'h2, rdat);
    chk("asel_dev", 32'(rdat), 32'h7E);
    bus_rd(23'h4, rdat);
    chk("asel_other", 32'(rdat), 32'h00);
    bus_wr(23'h0, 8'hF0);
    chk("asel_exit_ovr", 32'(dout_ovr), 32'h0);
    chk("asel_exit_dout", 32'(dout), 32'hFF);

    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h66);
    bus_wr(23'hAAA, 8'hA0);
    bus_wr(23'h000100, 8'h12);
    repeat (4) @(negedge clk);
    chk("broken_req", 32'(ram_req), 32'h0);
    chk("broken_busy", 32'(busy), 32'h0);
    chk("broken_acks", 32'(acks), 32'h1);

`ifndef FLASH_CHIP_ERASE_EN
    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h55);
    bus_wr(23'hAAA, 8'h80);
    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h55);
    bus_wr(23'hAAA, 8'h10);
    repeat (4) @(negedge clk);
    chk("chip_off_req", 32'(ram_req), 32'h0);
    chk("chip_off_busy", 32'(busy), 32'h0);
    chk("chip_off_acks", 32'(acks), 32'h1);
`endif

    ack_wait = 0;
    acks = 0;
    for (int i = 0; i < 65536; i++) sb.push_back({23'h1A0000 + 23'(i), 8'hFF});
    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h55);
    bus_wr(23'hAAA, 8'h80);
    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h55);
    bus_wr(23'h1ABCDE, 8'h30);
    chk("erase_busy", 32'(busy), 32'h1);
    chk("erase_req", 32'(ram_req), 32'h1);
    bus_rd(23'h0, rdat);
    chk("erase_stat0", 32'(rdat), 32'h08);
    bus_rd(23'h0, rdat);
    chk("erase_stat1", 32'(rdat), 32'h48);
    bus_wr(23'h0, 8'hF0);
    chk("erase_f0_ignored", 32'(busy), 32'h1);
    wait_idle(70000);
    chk("erase_acks", acks, 32'd65536);
    chk("erase_sb_empty", 32'(sb.size()), 32'h0);
    chk("erase_ovr_end", 32'(dout_ovr), 32'h0);
    chk("erase_req_end", 32'(ram_req), 32'h0);

    acks = 0;
    for (int i = 0; i < 65536; i++) sb.push_back({23'(i), 8'hFF});
    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h55);
    bus_wr(23'hAAA, 8'h80);
    bus_wr(23'hAAA, 8'hAA);
    bus_wr(23'h555, 8'h55);
    bus_wr(23'h000000, 8'h30);
    repeat (100) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    #2 reset = 1;
    #1;
    chk("mid_rst_req", 32'(ram_req), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    sb.delete();
    @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    chk("mid_no_resume_req", 32'(ram_req), 32'h0);
    chk("mid_no_resume_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/flash_cmd_engine.md
Name: flash_cmd_engine

Overview:
- Emulates the AMD/JEDEC-style NOR flash command interpreter behind the MFR SD cartridge mapper's flash bus.
- Consumes the mapper's byte-wide flash cycles and decodes unlock/command sequences (program, sector erase, chip erase, autoselect, reset).
- Issues byte writes to the SDRAM backing store through a req/ack handshake.
- Supplies status and ID bytes that override array reads while busy or in autoselect.

Parameters:
- ADDR_W, 23, byte address width of the flash array (8 MB).
- SECTOR_W, 16, log2 of the sector size in bytes (64 KB uniform sectors).
- MANUF_ID, 8'h01, autoselect manufacturer byte (addr[7:0]=00).
- DEVICE_ID, 8'h7E, autoselect device byte (addr[7:0]=02).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  flash chip select from the mapper; qualifies wr/rd.
- addr  in  ADDR_W  byte address of the current cycle.
- din  in  8  write data.
- wr  in  1  single-cycle write strobe.
- rd  in  1  single-cycle read strobe.
- dout  out  8  status/ID byte, valid when dout_ovr=1.
- dout_ovr  out  1  1 = reader must use dout instead of array data.
- busy  out  1  embedded program/erase in progress.
- ram_addr  out  ADDR_W  backing-store write address.
- ram_din  out  8  backing-store write data.
- ram_req  out  1  write request; held until ram_ack.
- ram_ack  in  1  single-cycle completion from the SDRAM arbiter.

Behaviour:
- Reset values: state=READ, dout=8'hFF, dout_ovr=0, busy=0, ram_req=0, ram_addr=0, ram_din=8'hFF, toggle bit=0.
- A bus write is ce&wr. A bus read is ce&rd. Command matching uses addr[11:0] only (byte mode: AAA/555).
- States: READ, UNLK1, UNLK2, PROG, ASEL, E_80, E_UNLK1, E_UNLK2, BUSY_PROG, BUSY_ERASE.
- READ: AAA<-AA goes to UNLK1.
- UNLK1: 555<-55 goes to UNLK2.
- UNLK2: AAA<-A0 goes to PROG. AAA<-90 goes to ASEL. AAA<-80 goes to E_80.
- E_80: AAA<-AA goes to E_UNLK1. E_UNLK1: 555<-55 goes to E_UNLK2.
- E_UNLK2: any addr<-30 starts a sector erase; the base is addr with low SECTOR_W bits cleared, length 2^SECTOR_W. AAA<-10 starts a chip erase (base 0, length 2^ADDR_W).
- Any non-matching write in UNLK1/UNLK2/E_* returns to READ. Data F0 at any address in any non-busy state returns to READ.
- ASEL: dout_ovr=1. dout=MANUF_ID when addr[7:0]=00, DEVICE_ID when 02, 8'h00 otherwise. Stays in ASEL until F0.
- PROG: the next write latches addr/din into ram_addr/ram_din, asserts ram_req on the following cycle, and enters BUSY_PROG. Program data is written verbatim, with no AND-with-existing semantics.
- BUSY_PROG: on ram_ack, deassert ram_req the same cycle and return to READ on the next clock. Total latency = 1 + arbiter wait + 1.
- BUSY_ERASE: a counter walks base..base+len-1. ram_din=FF. ram_req stays asserted while work remains. Each ram_ack increments ram_addr. The ack on the last byte clears ram_req and returns to READ. The counter is ADDR_W+1 bits wide so a chip erase terminates without wrap-around.
- busy=1 exactly in BUSY_PROG and BUSY_ERASE. All writes are ignored while busy, including F0.
- Status while busy: dout_ovr=1.
  - DQ7 = ~latched din[7] during program, 0 during erase.
  - DQ6 = toggle bit, inverted on every bus read while busy.
  - DQ5 = 0. DQ3 = 1 during erase, 0 during program. Other bits 0.
- Toggle bit resets to 0 on entering READ.
- rd and wr asserted together: the write takes priority and the toggle does not advance.
- ram_ack while ram_req=0 is ignored.
- Reset mid-operation: ram_req drops immediately (asynchronously). An erase left incomplete is not resumed.

Optional Feature:
- FLASH_CHIP_ERASE_EN.
- Defined: the AAA<-10 chip-erase command is accepted as above.
- Undefined: AAA<-10 in E_UNLK2 is treated as a non-matching write and returns to READ with no RAM traffic. The erase counter narrows to ADDR_W bits. SECTOR_W-wide logic may be used for the erase length.

Decomposition:
- Shared package flash_pkg:
  - typedef enum flash_state_t (the states above).
  - Command byte constants CMD_UNLK1=AA, CMD_UNLK2=55, CMD_PROG=A0, CMD_ASEL=90, CMD_ERASE=80, CMD_SECT=30, CMD_CHIP=10, CMD_RESET=F0.
  - Address constants ADDR_UNLK1=12'hAAA, ADDR_UNLK2=12'h555.
- Natural sub-module: flash_erase_walker, which holds the base/length counter and req/ack sequencing; BUSY_ERASE starts it and waits on its done pulse.

Test Plan:
- Program: AAA<-AA, 555<-55, AAA<-A0, 012345<-3C -> ram_req with ram_addr=012345, ram_din=3C. Read during busy gives dout=8'h80 | DQ6 toggling. Ack after 3 cycles -> busy=0, dout_ovr=0.
- Sector erase at addr 0x1A_BCDE with ack every cycle -> exactly 65536 ram_req/ack pairs, addresses 0x1A0000..0x1AFFFF, data FF. DQ3=1 during the erase.
- Autoselect: 90 sequence, then read addr 00 -> 01 and addr 02 -> 7E. Write F0 -> dout_ovr=0.
- Broken sequence: AAA<-AA then 555<-66 -> state READ. A following AAA<-A0 does not program.
- Write F0 during BUSY_ERASE -> ignored and erase completes. Assert reset mid-erase -> ram_req=0 immediately and busy=0.
- FLASH_CHIP_ERASE_EN undefined: chip-erase sequence -> no ram_req and state READ. Defined: the counter reaches 2^23 acks and returns to READ.
